// File: rtl/comb_decimator.sv
// Decimating comb stage: keeps every R-th accepted sample and outputs
// y[k] = x[k] - x[k-M] (modulo 2^I_BW), truncated to the top O_BW bits.
module comb_decimator #(
   parameter int I_BW = 8,
   parameter int O_BW = 8,
   parameter int R    = 4,
   parameter int M    = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_i,
   input  logic                   clr_i,
   input  logic signed [I_BW-1:0] data_i,
   input  logic                   valid_i,
   output logic signed [O_BW-1:0] data_o,
   output logic                   valid_o
);

   localparam int CW = (R > 1) ? $clog2(R) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

   logic [CW-1:0]          cnt_q, cnt_d;
   logic [I_BW-1:0]        dly_q [M];
   logic [I_BW-1:0]        dly_d [M];
   logic signed [O_BW-1:0] data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   accept_s;
   logic                   keep_s;
   logic [I_BW-1:0]        diff_s;

   always_comb begin
      accept_s = en_i && valid_i && !clr_i;
      keep_s   = accept_s && (cnt_q == CNT_LAST);
      // Modular subtraction: wrap-around is the intended CIC behaviour.
      diff_s   = data_i - dly_q[M-1];
      cnt_d    = cnt_q;
      dly_d    = dly_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      if (clr_i) begin
         cnt_d  = '0;
         data_d = '0;
         for (int i = 0; i < M; i++) begin
            dly_d[i] = '0;
         end
      end else if (keep_s) begin
         cnt_d    = '0;
         dly_d[0] = data_i;
         for (int i = 1; i < M; i++) begin
            dly_d[i] = dly_q[i-1];
         end
         data_d  = $signed(diff_s[I_BW-1 -: O_BW]);
         valid_d = 1'b1;
      end else if (accept_s) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < M; i++) begin
            dly_q[i] <= '0;
         end
      end else begin
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         for (int i = 0; i < M; i++) begin
            dly_q[i] <= dly_d[i];
         end
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_comb_decimator.sv
// Directed bench for comb_decimator: two instances (R=4,M=1,8->8 and
// R=2,M=2,8->4) share stimulus and are checked against a kept-sample model.
module tb_comb_decimator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] din = 8'd0;

   logic signed [7:0] a_data;
   logic              a_valid;
   logic signed [3:0] b_data;
   logic              b_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   comb_decimator #(.I_BW(8), .O_BW(8), .R(4), .M(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
      .data_i(din), .valid_i(valid), .data_o(a_data), .valid_o(a_valid)
   );

   comb_decimator #(.I_BW(8), .O_BW(4), .R(2), .M(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
      .data_i(din), .valid_i(valid), .data_o(b_data), .valid_o(b_valid)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: list of kept samples since the last clear/reset, per instance.
   int pr [2] = '{4, 2};
   int pm [2] = '{1, 2};
   int po [2] = '{8, 4};
   int m_cnt [2];
   int m_hn [2];
   int m_hist [2][64];
   int exp_d [2];
   int exp_v [2];

   task automatic model_reset(input int i);
      m_cnt[i] = 0;
      m_hn[i]  = 0;
      exp_d[i] = 0;
      exp_v[i] = 0;
   endtask

   task automatic model_step(input int i);
      int x, prev, diff;
      if (clr) begin
         model_reset(i);
      end else if (en && valid) begin
         if (m_cnt[i] == pr[i] - 1) begin
            m_cnt[i] = 0;
            x    = int'(din);
            prev = (m_hn[i] >= pm[i]) ? m_hist[i][m_hn[i] - pm[i]] : 0;
            diff = (x - prev) & 255;
            exp_d[i] = diff >> (8 - po[i]);
            exp_v[i] = 1;
            if (m_hn[i] < 64) begin
               m_hist[i][m_hn[i]] = x;
               m_hn[i]++;
            end
         end else begin
            m_cnt[i]++;
            exp_v[i] = 0;
         end
      end else begin
         exp_v[i] = 0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   int got_a[$];
   int got_b[$];

   // Cycle-by-cycle comparison against the model, plus output capture.
   always @(negedge clk) begin
      check("a_valid", int'(a_valid), exp_v[0]);
      check("a_data", int'({24'd0, a_data}), exp_d[0]);
      check("b_valid", int'(b_valid), exp_v[1]);
      check("b_data", int'({28'd0, b_data}), exp_d[1]);
      if (a_valid) got_a.push_back(int'({24'd0, a_data}));
      if (b_valid) got_b.push_back(int'({28'd0, b_data}));
   end

   task automatic step(input logic e, input logic v, input logic c, input logic [7:0] d);
      en = e; valid = v; clr = c; din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0; valid = 1'b0; clr = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      got_a.delete();
      got_b.delete();
   endtask

   task automatic settle();
      step(1'b1, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      #1;
   endtask

   task automatic check_q(input string name, input int got[$], input int exp[$]);
      check({name, "_count"}, got.size(), exp.size());
      for (int k = 0; k < exp.size() && k < got.size(); k++) begin
         check(name, got[k], exp[k]);
      end
   endtask

   initial begin
      int exp_q[$];

      // Reset state
      rst = 1'b1;
      #1;
      check("rst_a_data", int'({24'd0, a_data}), 0);
      check("rst_a_valid", int'(a_valid), 0);
      check("rst_b_data", int'({28'd0, b_data}), 0);
      do_reset();

      // Ramp 0..15
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'(i));
         check("ramp_pulse", int'(a_valid), (i % 4 == 3) ? 1 : 0);
      end
      settle();
      exp_q = '{3, 4, 4, 4};
      check_q("ramp_data", got_a, exp_q);

      // Modular wrap: kept 124 then -128
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0, (i == 3) ? 8'd124 : ((i == 7) ? 8'h80 : 8'(i)));
      end
      settle();
      exp_q = '{124, 4};
      check_q("wrap_data", got_a, exp_q);

      // Stall/gaps with en low mid-group
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'd77);
         step(1'b1, 1'b1, 1'b0, 8'(i));
         if (i == 5) begin
            for (int k = 0; k < 3; k++) begin
               step(1'b0, 1'b1, 1'b0, 8'd99);
               check("stall_en_low_valid", int'(a_valid), 0);
            end
         end
      end
      settle();
      exp_q = '{3, 4, 4, 4};
      check_q("stall_data", got_a, exp_q);

      // Clear priority at cnt=2
      do_reset();
      step(1'b1, 1'b1, 1'b0, 8'd0);
      step(1'b1, 1'b1, 1'b0, 8'd1);
      step(1'b1, 1'b1, 1'b1, 8'd99);
      step(1'b1, 1'b1, 1'b0, 8'd10);
      step(1'b1, 1'b1, 1'b0, 8'd20);
      step(1'b1, 1'b1, 1'b0, 8'd30);
      step(1'b1, 1'b1, 1'b0, 8'd40);
      settle();
      exp_q = '{40};
      check_q("clr_data", got_a, exp_q);

      // Async reset mid-operation
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'(i));
      end
      check("pre_arst_data", int'({24'd0, a_data}), 3);
      rst = 1'b1;
      #1;
      check("arst_a_data", int'({24'd0, a_data}), 0);
      check("arst_a_valid", int'(a_valid), 0);
      #1;
      rst = 1'b0;
      got_a.delete();
      got_b.delete();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'(10 + i));
         check("arst_phase", int'(a_valid), (i == 3) ? 1 : 0);
      end
      settle();
      exp_q = '{13};
      check_q("arst_data", got_a, exp_q);

      // Scaling/delay on R=2, M=2, O_BW=4 instance
      do_reset();
      step(1'b1, 1'b1, 1'b0, 8'd5);
      step(1'b1, 1'b1, 1'b0, 8'd0);
      step(1'b1, 1'b1, 1'b0, 8'd7);
      step(1'b1, 1'b1, 1'b0, 8'd32);
      step(1'b1, 1'b1, 1'b0, 8'd9);
      step(1'b1, 1'b1, 1'b0, 8'd64);
      step(1'b1, 1'b1, 1'b0, 8'd11);
      step(1'b1, 1'b1, 1'b0, 8'd96);
      settle();
      exp_q = '{0, 2, 4, 4};
      check_q("scale_data", got_b, exp_q);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
